// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle RV32 control FSM: states, opcodes,
// datapath select codes and the decoded control bundle.
package multicycle_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FETCH      = 3'd1,
        S_DECODE     = 3'd2,
        S_EXECUTE    = 3'd3,
        S_WRITE_BACK = 3'd4,
        S_MEM        = 3'd5,
        S_HALT       = 3'd6
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] ALU_ADD     = 2'b00;
    localparam logic [1:0] ALU_SUB     = 2'b01;
    localparam logic [1:0] ALU_FUNCT_R = 2'b10;
    localparam logic [1:0] ALU_FUNCT_I = 2'b11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef struct packed {
        logic       we_reg;
        logic       we_mem;
        logic       mux4;
        logic [1:0] mux2;
        logic       mux1;
        logic [1:0] aluop;
    } ctrl_bundle_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational opcode decoder: maps an opcode onto the datapath control
// bundle and flags opcodes outside the supported RV32 subset.
module ctrl_decode
    import multicycle_pkg::*;
#(
    parameter int OPCODE_W = 7
) (
    input  logic [OPCODE_W-1:0] op,
    output ctrl_bundle_t        ctrl,
    output logic                legal
);

    always_comb begin
        ctrl  = '0;
        legal = 1'b1;
        case (op)
            OPCODE_W'(OP_LOAD): begin
                ctrl.we_reg = 1'b1;
                ctrl.mux2   = WB_MEM;
                ctrl.mux1   = 1'b1;
                ctrl.aluop  = ALU_ADD;
            end
            OPCODE_W'(OP_STORE): begin
                ctrl.we_mem = 1'b1;
                ctrl.mux1   = 1'b1;
                ctrl.aluop  = ALU_ADD;
            end
            OPCODE_W'(OP_RTYPE): begin
                ctrl.we_reg = 1'b1;
                ctrl.mux2   = WB_ALU;
                ctrl.aluop  = ALU_FUNCT_R;
            end
            OPCODE_W'(OP_ITYPE): begin
                ctrl.we_reg = 1'b1;
                ctrl.mux2   = WB_ALU;
                ctrl.mux1   = 1'b1;
                ctrl.aluop  = ALU_FUNCT_I;
            end
            OPCODE_W'(OP_BRANCH): begin
                ctrl.aluop = ALU_SUB;
            end
            OPCODE_W'(OP_JAL): begin
                ctrl.we_reg = 1'b1;
                ctrl.mux2   = WB_PC4;
                ctrl.mux4   = 1'b1;
                ctrl.aluop  = ALU_ADD;
            end
            OPCODE_W'(OP_JALR): begin
                ctrl.we_reg = 1'b1;
                ctrl.mux2   = WB_PC4;
                ctrl.mux4   = 1'b1;
                ctrl.mux1   = 1'b1;
                ctrl.aluop  = ALU_ADD;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM with memory handshake, configurable write-back
// length and sticky illegal-opcode trap. MULTICYCLE_CTRL_PERF_EN adds counters.
//
// state      | meaning
// IDLE       | waiting for run at an instruction boundary
// FETCH      | instruction read, IR loads on mem_ready
// DECODE     | opcode latched and checked
// EXECUTE    | ALU operation; branches retire here
// WRITE_BACK | register write for WB_CYCLES cycles, PC update on last
// MEM        | data access; stores retire here
// HALT       | illegal opcode trap, left only by reset
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int OPCODE_W  = 7,
    parameter int STATE_W   = 4,
    parameter int WB_CYCLES = 1,
    parameter int CNT_W     = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                alu_zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic [STATE_W-1:0]  state_reg,
    output logic [1:0]          aluop,
    output logic                mux1,
    output logic [1:0]          mux2,
    output logic                mux4,
    output logic                we_ir,
    output logic                we_reg,
    output logic                we_mem,
    output logic                we_pc,
    output logic                illegal
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]    instret,
    output logic [CNT_W-1:0]    stall_cnt
`endif
);

    localparam logic [STATE_W-1:0] ST_IDLE       = STATE_W'(S_IDLE);
    localparam logic [STATE_W-1:0] ST_FETCH      = STATE_W'(S_FETCH);
    localparam logic [STATE_W-1:0] ST_DECODE     = STATE_W'(S_DECODE);
    localparam logic [STATE_W-1:0] ST_EXECUTE    = STATE_W'(S_EXECUTE);
    localparam logic [STATE_W-1:0] ST_WRITE_BACK = STATE_W'(S_WRITE_BACK);
    localparam logic [STATE_W-1:0] ST_MEM        = STATE_W'(S_MEM);
    localparam logic [STATE_W-1:0] ST_HALT       = STATE_W'(S_HALT);
    localparam logic [7:0]         WB_LAST       = 8'(WB_CYCLES - 1);

    logic [STATE_W-1:0]  state_q;
    logic [OPCODE_W-1:0] op_q;
    logic [7:0]          wb_cnt;
    logic                illegal_q;

    logic [OPCODE_W-1:0] dec_op;
    ctrl_bundle_t        ctrl;
    logic                legal;
    logic                is_ld;
    logic                is_st;
    logic                is_br;
    logic                wb_last;
    logic [STATE_W-1:0]  boundary_next;

    // In DECODE the fresh opcode is checked; everywhere else the latched one drives the datapath.
    assign dec_op = (state_q == ST_DECODE) ? opcode : op_q;

    ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .op    (dec_op),
        .ctrl  (ctrl),
        .legal (legal)
    );

    assign is_ld         = (op_q == OPCODE_W'(OP_LOAD));
    assign is_st         = (op_q == OPCODE_W'(OP_STORE));
    assign is_br         = (op_q == OPCODE_W'(OP_BRANCH));
    assign wb_last       = (wb_cnt == WB_LAST);
    assign boundary_next = run ? ST_FETCH : ST_IDLE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            wb_cnt    <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run) state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (mem_ready) state_q <= ST_DECODE;
                end
                ST_DECODE: begin
                    op_q <= opcode;
                    if (legal) begin
                        state_q <= ST_EXECUTE;
                    end else begin
                        state_q   <= ST_HALT;
                        illegal_q <= 1'b1;
                    end
                end
                ST_EXECUTE: begin
                    if (is_br) begin
                        state_q <= boundary_next;
                    end else if (is_ld || is_st) begin
                        state_q <= ST_MEM;
                    end else begin
                        state_q <= ST_WRITE_BACK;
                        wb_cnt  <= '0;
                    end
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        if (is_ld) begin
                            state_q <= ST_WRITE_BACK;
                            wb_cnt  <= '0;
                        end else begin
                            state_q <= boundary_next;
                        end
                    end
                end
                ST_WRITE_BACK: begin
                    if (wb_last) state_q <= boundary_next;
                    else         wb_cnt  <= wb_cnt + 8'd1;
                end
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req = 1'b0;
        aluop   = '0;
        mux1    = 1'b0;
        mux2    = '0;
        mux4    = 1'b0;
        we_ir   = 1'b0;
        we_reg  = 1'b0;
        we_mem  = 1'b0;
        we_pc   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                we_ir   = mem_ready;
            end
            ST_EXECUTE: begin
                aluop = ctrl.aluop;
                mux1  = ctrl.mux1;
                if (is_br) begin
                    we_pc = 1'b1;
                    mux4  = alu_zero;
                end
            end
            ST_MEM: begin
                mem_req = 1'b1;
                we_mem  = ctrl.we_mem & mem_ready;
                we_pc   = is_st & mem_ready;
            end
            ST_WRITE_BACK: begin
                we_reg = ctrl.we_reg;
                mux2   = ctrl.mux2;
                if (wb_last) begin
                    we_pc = 1'b1;
                    mux4  = ctrl.mux4;
                end
            end
            default: ;
        endcase
    end

    assign state_reg = state_q;
    assign illegal   = illegal_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instret   <= '0;
            stall_cnt <= '0;
        end else begin
            if (we_pc)                  instret   <= instret + 1'b1;
            if (mem_req && !mem_ready)  stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into its
// expected per-cycle trace and compared against the DUT, including stalls,
// run toggling, the illegal-opcode trap and asynchronous reset mid-access.
module tb_multicycle_ctrl;

    localparam int WB = 3;
    localparam int CW = 32;

    localparam logic [3:0] T_IDLE = 4'd0, T_FETCH = 4'd1, T_DECODE = 4'd2,
                           T_EXEC = 4'd3, T_WB = 4'd4, T_MEM = 4'd5, T_HALT = 4'd6;

    localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BR = 7'b1100011, JAL = 7'b1101111,
                           JALR = 7'b1100111, BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       run = 1'b0;
    logic [6:0] opcode = '0;
    logic       alu_zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mux1, mux4, we_ir, we_reg, we_mem, we_pc, illegal;
    logic [3:0] state_reg;
    logic [1:0] aluop, mux2;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [CW-1:0] instret, stall_cnt;
`endif

    always #5 clk = ~clk;

    multicycle_ctrl #(.OPCODE_W(7), .STATE_W(4), .WB_CYCLES(WB), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run),
        .opcode    (opcode),
        .alu_zero  (alu_zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .state_reg (state_reg),
        .aluop     (aluop),
        .mux1      (mux1),
        .mux2      (mux2),
        .mux4      (mux4),
        .we_ir     (we_ir),
        .we_reg    (we_reg),
        .we_mem    (we_mem),
        .we_pc     (we_pc),
        .illegal   (illegal)
`ifdef MULTICYCLE_CTRL_PERF_EN
        ,
        .instret   (instret),
        .stall_cnt (stall_cnt)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    typedef struct {
        logic [3:0] st;
        logic       mr, az;
        logic [6:0] opc;
        logic       mem_req, we_ir, we_reg, we_mem, we_pc, mux1, mux4;
        logic [1:0] aluop, mux2;
        logic       last;
    } cyc_t;

    logic          illegal_exp = 1'b0;
    logic [CW-1:0] instret_exp = '0;
    logic [CW-1:0] stall_exp   = '0;
    bit            in_idle     = 1'b1;
    logic [6:0]    ops [7]     = '{LD, ST, RT, IT, BR, JAL, JALR};

    function automatic cyc_t blank(input logic [3:0] st);
        cyc_t c;
        c.st = st;   c.mr = 1'($urandom); c.az = 1'($urandom); c.opc = 7'($urandom);
        c.mem_req = 0; c.we_ir = 0; c.we_reg = 0; c.we_mem = 0; c.we_pc = 0;
        c.mux1 = 0; c.mux4 = 0; c.aluop = 0; c.mux2 = 0; c.last = 0;
        return c;
    endfunction

    function automatic logic [11:0] exp_vec(input cyc_t c);
        return {c.mem_req, c.we_ir, c.we_reg, c.we_mem, c.we_pc, c.mux1, c.mux4,
                c.aluop, c.mux2, illegal_exp};
    endfunction

    function automatic logic [11:0] obs_vec();
        return {mem_req, we_ir, we_reg, we_mem, we_pc, mux1, mux4, aluop, mux2, illegal};
    endfunction

    function automatic bit legal_op(input logic [6:0] op);
        return op inside {LD, ST, RT, IT, BR, JAL, JALR};
    endfunction

    function automatic logic [1:0] aluop_of(input logic [6:0] op);
        if (op == BR) return 2'b01;
        if (op == RT) return 2'b10;
        if (op == IT) return 2'b11;
        return 2'b00;
    endfunction

    // One clock: drive inputs after the falling edge, then compare outputs.
    task automatic play(input cyc_t c, input int run_mode, output logic run_v);
        @(negedge clk);
        run_v     = (run_mode == 2) ? 1'($urandom) : 1'(run_mode);
        run       = run_v;
        mem_ready = c.mr;
        alu_zero  = c.az;
        opcode    = c.opc;
        #1;
        chk("state", 32'(state_reg), 32'(c.st));
        chk("ctrl", 32'(obs_vec()), 32'(exp_vec(c)));
`ifdef MULTICYCLE_CTRL_PERF_EN
        chk("instret", instret, instret_exp);
        chk("stall_cnt", stall_cnt, stall_exp);
        if (c.we_pc) instret_exp++;
        if (c.mem_req && !c.mr) stall_exp++;
`endif
    endtask

    task automatic do_instr(input logic [6:0] op, input int fw, input int mw, input int az_sel);
        cyc_t q[$];
        cyc_t c;
        logic r;
        if (in_idle) begin
            c = blank(T_IDLE);
            play(c, 1, r);
        end
        for (int i = 0; i <= fw; i++) begin
            c = blank(T_FETCH); c.mr = (i == fw); c.mem_req = 1; c.we_ir = c.mr;
            q.push_back(c);
        end
        c = blank(T_DECODE); c.opc = op;
        q.push_back(c);
        if (legal_op(op)) begin
            c = blank(T_EXEC);
            c.aluop = aluop_of(op);
            c.mux1  = op inside {LD, ST, IT, JALR};
            if (op == BR) begin
                if (az_sel < 2) c.az = az_sel[0];
                c.we_pc = 1; c.mux4 = c.az; c.last = 1;
            end
            q.push_back(c);
            if (op == LD || op == ST) begin
                for (int i = 0; i <= mw; i++) begin
                    c = blank(T_MEM); c.mr = (i == mw); c.mem_req = 1;
                    if (op == ST && c.mr) begin
                        c.we_mem = 1; c.we_pc = 1; c.last = 1;
                    end
                    q.push_back(c);
                end
            end
            if (op != BR && op != ST) begin
                for (int i = 0; i < WB; i++) begin
                    c = blank(T_WB); c.we_reg = 1;
                    c.mux2 = (op == LD) ? 2'b01 : (op == JAL || op == JALR) ? 2'b10 : 2'b00;
                    if (i == WB - 1) begin
                        c.we_pc = 1; c.mux4 = (op == JAL || op == JALR); c.last = 1;
                    end
                    q.push_back(c);
                end
            end
        end
        foreach (q[i]) begin
            play(q[i], 2, r);
            if (q[i].last) in_idle = !r;
        end
        if (!legal_op(op)) begin
            illegal_exp = 1'b1;
            for (int k = 0; k < 8; k++) begin
                c = blank(T_HALT);
                play(c, 2, r);
            end
        end else if (in_idle) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                c = blank(T_IDLE);
                play(c, 0, r);
            end
        end
    endtask

    task automatic reset_checks();
        #1;
        chk("rst_state", 32'(state_reg), 32'(T_IDLE));
        chk("rst_ctrl", 32'(obs_vec()), 32'd0);
`ifdef MULTICYCLE_CTRL_PERF_EN
        chk("rst_instret", instret, '0);
        chk("rst_stall", stall_cnt, '0);
`endif
    endtask

    task automatic release_reset();
        @(negedge clk);
        run = 1'b0;
        #2 reset_n = 1'b1;
        illegal_exp = 1'b0; instret_exp = '0; stall_exp = '0; in_idle = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        run = 1'b1; mem_ready = 1'b0;
        reset_n = 1'b0;
        reset_checks();
        release_reset();
    endtask

    // Load stalled in MEM, reset lands asynchronously mid-access.
    task automatic reset_in_mem();
        cyc_t c;
        logic r;
        if (in_idle) begin c = blank(T_IDLE); play(c, 1, r); end
        c = blank(T_FETCH); c.mr = 1; c.mem_req = 1; c.we_ir = 1; play(c, 2, r);
        c = blank(T_DECODE); c.opc = LD; play(c, 2, r);
        c = blank(T_EXEC); c.mux1 = 1; play(c, 2, r);
        for (int i = 0; i < 2; i++) begin
            c = blank(T_MEM); c.mr = 0; c.mem_req = 1; play(c, 2, r);
        end
        #1 reset_n = 1'b0;
        reset_checks();
        release_reset();
        for (int k = 0; k < 4; k++) begin
            c = blank(T_IDLE); play(c, 0, r);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        run = 1'b1; mem_ready = 1'b1; opcode = RT;
        repeat (3) @(negedge clk);
        reset_checks();
        release_reset();

        do_instr(RT, 0, 0, 2);
        do_instr(LD, 0, 3, 2);
        do_instr(IT, 0, 0, 2);
        do_instr(BR, 0, 0, 1);
        do_instr(BR, 0, 0, 0);
        do_instr(ST, 1, 2, 2);
        do_instr(JAL, 0, 0, 2);
        do_instr(JALR, 2, 0, 2);

        for (int n = 0; n < 60; n++)
            do_instr(ops[$urandom_range(0, 6)], $urandom_range(0, 2), $urandom_range(0, 3), 2);

        reset_in_mem();
        do_instr(RT, 0, 0, 2);
        do_instr(BAD, 2, 0, 2);
        do_reset();
        do_instr(IT, 1, 0, 2);
        for (int n = 0; n < 20; n++)
            do_instr(ops[$urandom_range(0, 6)], $urandom_range(0, 2), $urandom_range(0, 3), 2);
        do_instr(7'($urandom_range(0, 127)) | 7'b0000100, 0, 0, 2);
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Parametrised successor to the fixed five-state control FSM. It sequences a multicycle RV32 datapath through FETCH/DECODE/EXECUTE/MEM/WRITE_BACK, and waits on a memory ready handshake. It decodes the latched opcode into the datapath control bundle, holds write-back for a configurable number of cycles, and traps illegal opcodes. It sits between the instruction register/opcode field and the datapath muxes, register file, data memory and PC enables.

Parameters:
OPCODE_W, 7, opcode field width
STATE_W, 4, state register width; must be >= 3
WB_CYCLES, 1, cycles spent in WRITE_BACK; legal range 1..255
CNT_W, 32, width of performance counters (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
run  in  1  1 = keep executing; sampled only at instruction boundaries
opcode  in  OPCODE_W  opcode field from IR; valid in DECODE
alu_zero  in  1  ALU zero flag; used for branch resolution in EXECUTE
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request (FETCH, or MEM state)
state_reg  out  STATE_W  current state, for debug and trace
aluop  out  2  00 add (ld/st/jal/jalr), 01 sub (branch), 10 R-type funct, 11 I-type funct
mux1  out  1  ALU B source: 0 rs2, 1 immediate
mux2  out  2  WB source: 00 ALU, 01 memory, 10 PC+4
mux4  out  1  PC source: 0 PC+4, 1 target
we_ir  out  1  IR write enable
we_reg  out  1  register file write enable
we_mem  out  1  data memory write enable
we_pc  out  1  PC write enable
illegal  out  1  sticky illegal-opcode flag

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITE_BACK=4, MEM=5, HALT=6. Any other encoding goes to IDLE on the next edge.
- Reset (asynchronous, any time including mid-memory-access): state=IDLE, op_q=0, wb_cnt=0, illegal=0. All outputs are 0 while reset_n=0.
- Outputs are Moore: combinational from state, op_q, wb_cnt and alu_zero/mem_ready only where stated. Outputs not listed for a state are 0.
- IDLE: go to FETCH when run=1.
- FETCH: mem_req=1. we_ir=mem_ready. Stay in FETCH while mem_ready=0; go to DECODE on mem_ready=1.
- DECODE: op_q<=opcode.
  - Legal opcodes: 0000011 ld, 0100011 st, 0110011 R, 0010011 I, 1100011 br, 1101111 jal, 1100111 jalr.
  - Illegal opcode: go to HALT and set illegal=1.
  - Otherwise go to EXECUTE.
- EXECUTE: drive aluop/mux1 from op_q.
  - ld/st/I/jalr: mux1=1.
  - br: we_pc=1. mux4 = alu_zero (BEQ-style). Then go to boundary.
  - ld/st: go to MEM.
  - Others: go to WRITE_BACK.
- MEM: mem_req=1. we_mem = (st & mem_ready).
  - Stay while mem_ready=0.
  - ld: go to WRITE_BACK.
  - st: we_pc=1 (mux4=0) on the completing cycle, then go to boundary.
- WRITE_BACK: we_reg=1 every cycle. mux2 = 01 for ld, 10 for jal/jalr, else 00.
  - wb_cnt counts 0..WB_CYCLES-1.
  - On the last count: we_pc=1, mux4 = (jal|jalr), then go to boundary.
  - wb_cnt clears on entry.
- Boundary: next state is FETCH if run=1, else IDLE. run is ignored elsewhere; an instruction always completes.
- HALT: sticky; only reset_n exits. All enables stay 0.
- Latency with mem_ready tied 1 and WB_CYCLES=1:
  - R/I/jal/jalr: 4 cycles.
  - ld: 5 cycles.
  - st: 4 cycles.
  - br: 3 cycles.
  - Each mem_ready=0 cycle adds 1 cycle.
- we_pc is asserted exactly once per retired instruction.

Optional Feature:
MULTICYCLE_CTRL_PERF_EN.
- Defined: add outputs instret (CNT_W) and stall_cnt (CNT_W), both reset to 0.
  - instret increments on every we_pc=1 cycle.
  - stall_cnt increments on every mem_req=1 and mem_ready=0 cycle.
  - Both wrap at 2^CNT_W.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package multicycle_pkg holds:
  - state encodings
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL, OP_JALR)
  - aluop and mux2 encodings
  - a ctrl_bundle struct {we_reg, we_mem, mux4, mux2, mux1, aluop}
- One sub-module, ctrl_decode: pure combinational, op_q -> ctrl_bundle plus the legal flag. The FSM instantiates it.

Test Plan:
- reset_n pulsed low during MEM of a load -> next cycle state_reg=0, mem_req=0, all enables 0; no we_reg afterwards.
- run=1, mem_ready=1, opcode=0110011, WB_CYCLES=1 -> states 1,2,3,4,1. we_ir at cycle 0, we_reg and we_pc at cycle 3, aluop=10.
- Load with mem_ready low for 3 cycles in MEM -> MEM lasts 4 cycles, we_reg=1 with mux2=01 in WRITE_BACK, total 8 cycles.
- WB_CYCLES=3 with I-type -> we_reg high for 3 consecutive cycles, we_pc only on the 3rd.
- Branch with alu_zero=1 -> we_pc=1, mux4=1 in EXECUTE. With alu_zero=0 -> mux4=0. No we_reg in either case.
- opcode=1111111 -> HALT (6), illegal=1; run toggling has no effect. With MULTICYCLE_CTRL_PERF_EN defined: instret holds, stall_cnt counts the injected waits.
